// File: rtl/mldsa_pkg.sv
// Shared ML-DSA types and size limits for the M' formatter.
package mldsa_pkg;

  localparam int MSG_MAX_SIZE_DEF = 27672;
  localparam int MAX_CTX_LEN_DEF  = 2032;
  localparam int LEN_W_DEF        = 16;

  localparam int MSG_MAX_BYTES = MSG_MAX_SIZE_DEF / 8;
  localparam int CTX_MAX_BYTES = MAX_CTX_LEN_DEF / 8;
  localparam int CTX_LEN_LIMIT = 255;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    CTX,
    MSG,
    FIN,
    ERR
  } mprime_state_e;

endpackage

// File: rtl/mprime_byte_sel.sv
// Combinational byte select for M': header length byte, context byte or message byte.
module mprime_byte_sel
  import mldsa_pkg::*;
#(
  parameter int MSG_BYTES = MSG_MAX_BYTES,
  parameter int CTX_BYTES = CTX_MAX_BYTES,
  localparam int MSG_IW = $clog2(MSG_BYTES),
  localparam int CTX_IW = $clog2(CTX_BYTES)
) (
  input  mprime_state_e            state_i,
  input  logic [MSG_IW-1:0]        msg_idx_i,
  input  logic [CTX_IW-1:0]        ctx_idx_i,
  input  logic [7:0]               hdr_len_i,
  input  logic [8*MSG_BYTES-1:0]   msg_i,
  input  logic [8*CTX_BYTES-1:0]   ctx_i,
  output logic [7:0]               byte_o
);

  logic [MSG_BYTES-1:0][7:0] msg_b;
  logic [CTX_BYTES-1:0][7:0] ctx_b;

  assign msg_b = msg_i;
  assign ctx_b = ctx_i;

  // Pick the byte belonging to the given state; HDR0 and idle states give zero.
  always_comb begin
    byte_o = 8'h00;
    case (state_i)
      HDR1:    byte_o = hdr_len_i;
      CTX:     byte_o = ctx_b[ctx_idx_i];
      MSG:     byte_o = msg_b[msg_idx_i];
      default: byte_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/mprime_formatter.sv
// Streams M' = 0x00 || ctx_len || ctx || M one byte per cycle over valid/ready.
//
//   state | meaning
//   IDLE  | waiting for start; lengths latched on start
//   HDR0  | presenting the 0x00 domain-separator byte
//   HDR1  | presenting ctx_len[7:0]
//   CTX   | presenting context byte idx
//   MSG   | presenting message byte idx
//   FIN   | stream complete; done pulses on the following cycle
//   ERR   | request rejected; done and err pulse on the following cycle
//
// Outputs are registered from the next-state values, so the byte presented
// always matches state_q/idx_q and holds unchanged through a stall.
module mprime_formatter
  import mldsa_pkg::*;
#(
  parameter int MSG_MAX_SIZE = MSG_MAX_SIZE_DEF,
  parameter int MAX_CTX_LEN  = MAX_CTX_LEN_DEF,
  parameter int LEN_W        = LEN_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [MSG_MAX_SIZE-1:0] M,
  input  logic [LEN_W-1:0]        msg_len,
  input  logic [MAX_CTX_LEN-1:0]  ctx,
  input  logic [LEN_W-1:0]        ctx_len,
  output logic [7:0]              out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic [LEN_W-1:0]        mp_len,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int MSG_BYTES = MSG_MAX_SIZE / 8;
  localparam int CTX_BYTES = MAX_CTX_LEN / 8;
  localparam int MSG_IW    = $clog2(MSG_BYTES);
  localparam int CTX_IW    = $clog2(CTX_BYTES);

  localparam logic [LEN_W-1:0] ONE       = LEN_W'(1);
  localparam logic [LEN_W-1:0] HDR_BYTES = LEN_W'(2);
  localparam logic [LEN_W-1:0] LIM_CTX   = LEN_W'(CTX_LEN_LIMIT);
  localparam logic [LEN_W-1:0] LIM_CTXB  = LEN_W'(CTX_BYTES);
  localparam logic [LEN_W-1:0] LIM_MSGB  = LEN_W'(MSG_BYTES);

  mprime_state_e    state_q, state_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] ctx_len_q, ctx_len_d;
  logic [LEN_W-1:0] msg_len_q, msg_len_d;
  logic [LEN_W-1:0] mp_len_q, mp_len_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             hs;
  logic             reject;
  logic [7:0]       sel_byte;

  assign hs     = out_valid_q & out_ready;
  assign reject = (ctx_len > LIM_CTX) || (ctx_len > LIM_CTXB) || (msg_len > LIM_MSGB);

  mprime_byte_sel #(
    .MSG_BYTES (MSG_BYTES),
    .CTX_BYTES (CTX_BYTES)
  ) u_byte_sel (
    .state_i   (state_d),
    .msg_idx_i (idx_d[MSG_IW-1:0]),
    .ctx_idx_i (idx_d[CTX_IW-1:0]),
    .hdr_len_i (ctx_len_q[7:0]),
    .msg_i     (M[8*MSG_BYTES-1:0]),
    .ctx_i     (ctx[8*CTX_BYTES-1:0]),
    .byte_o    (sel_byte)
  );

  // Next-state, index and length-latch logic; advances only on a handshake.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ctx_len_d = ctx_len_q;
    msg_len_d = msg_len_q;
    mp_len_d  = mp_len_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          ctx_len_d = ctx_len;
          msg_len_d = msg_len;
          mp_len_d  = ctx_len + msg_len + HDR_BYTES;
          idx_d     = '0;
          state_d   = reject ? ERR : HDR0;
        end
      end
      HDR0: if (hs) state_d = HDR1;
      HDR1: begin
        if (hs) begin
          idx_d = '0;
          if (ctx_len_q != '0)      state_d = CTX;
          else if (msg_len_q != '0) state_d = MSG;
          else                      state_d = FIN;
        end
      end
      CTX: begin
        if (hs) begin
          if (idx_q == ctx_len_q - ONE) begin
            idx_d   = '0;
            state_d = (msg_len_q != '0) ? MSG : FIN;
          end else begin
            idx_d = idx_q + ONE;
          end
        end
      end
      MSG: begin
        if (hs) begin
          if (idx_q == msg_len_q - ONE) begin
            idx_d   = '0;
            state_d = FIN;
          end else begin
            idx_d = idx_q + ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output values for the byte that will be presented next cycle.
  always_comb begin
    out_valid_d = state_d inside {HDR0, HDR1, CTX, MSG};
    out_data_d  = sel_byte;
    out_last_d  = 1'b0;
    case (state_d)
      HDR1:    out_last_d = (ctx_len_q == '0) && (msg_len_q == '0);
      CTX:     out_last_d = (idx_d == ctx_len_q - ONE) && (msg_len_q == '0);
      MSG:     out_last_d = (idx_d == msg_len_q - ONE);
      default: out_last_d = 1'b0;
    endcase
    done_d = (state_q == FIN) || (state_q == ERR);
    err_d  = (state_q == ERR);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      ctx_len_q   <= '0;
      msg_len_q   <= '0;
      mp_len_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ctx_len_q   <= ctx_len_d;
      msg_len_q   <= msg_len_d;
      mp_len_q    <= mp_len_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign mp_len    = mp_len_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mprime_formatter.sv
// Scoreboard bench for mprime_formatter: stimulus pushes expected {last,byte}, monitor pops on handshake.
module tb_mprime_formatter;

  localparam int MSG_MAX_SIZE = 27672;
  localparam int MAX_CTX_LEN  = 2032;
  localparam int LEN_W        = 16;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    start = 1'b0;
  logic [MSG_MAX_SIZE-1:0] M = '0;
  logic [LEN_W-1:0]        msg_len = '0;
  logic [MAX_CTX_LEN-1:0]  ctx = '0;
  logic [LEN_W-1:0]        ctx_len = '0;
  logic [7:0]              out_data;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic                    out_last;
  logic [LEN_W-1:0]        mp_len;
  logic                    busy;
  logic                    done;
  logic                    err;

  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_q[$];
  bit         tog_mode = 1'b0;
  bit         hold_v = 1'b0;
  logic [8:0] held = '0;

  mprime_formatter #(
    .MSG_MAX_SIZE (MSG_MAX_SIZE),
    .MAX_CTX_LEN  (MAX_CTX_LEN),
    .LEN_W        (LEN_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .M         (M),
    .msg_len   (msg_len),
    .ctx       (ctx),
    .ctx_len   (ctx_len),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .mp_len    (mp_len),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Ready driver: held high, or toggling every cycle when tog_mode is set.
  always @(posedge clk) begin
    #1;
    out_ready = tog_mode ? ~out_ready : 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: compare each transferred byte with the scoreboard and check stall stability.
  always @(negedge clk) begin
    logic [8:0] e_b;
    if (!rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        checks++;
        if (!out_valid || {out_last, out_data} !== held) begin
          errors++;
          $display("FAIL stall_hold actual=%b_%b_%h required=1_%b_%h",
                   out_valid, out_last, out_data, held[8], held[7:0]);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte actual=%b_%h required=none", out_last, out_data);
        end else begin
          e_b = exp_q.pop_front();
          if ({out_last, out_data} !== e_b) begin
            errors++;
            $display("FAIL byte actual=last%b_%h required=last%b_%h",
                     out_last, out_data, e_b[8], e_b[7:0]);
          end
        end
        hold_v = 1'b0;
      end else if (out_valid) begin
        hold_v = 1'b1;
        held   = {out_last, out_data};
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  // Model of M' for the bench's own ctx/M stimulus.
  task automatic push_seq(input int cl, input int ml);
    exp_q.push_back({1'b0, 8'h00});
    exp_q.push_back({(cl == 0 && ml == 0), 8'(cl)});
    for (int i = 0; i < cl; i++) exp_q.push_back({(i == cl - 1 && ml == 0), ctx[8*i +: 8]});
    for (int i = 0; i < ml; i++) exp_q.push_back({(i == ml - 1), M[8*i +: 8]});
  endtask

  task automatic push_ab_123();
    exp_q.push_back(9'h000);
    exp_q.push_back(9'h002);
    exp_q.push_back(9'h061);
    exp_q.push_back(9'h062);
    exp_q.push_back(9'h011);
    exp_q.push_back(9'h022);
    exp_q.push_back(9'h133);
  endtask

  task automatic load_ab_123();
    ctx = '0;
    M   = '0;
    ctx[7:0]   = 8'h61;
    ctx[15:8]  = 8'h62;
    M[7:0]     = 8'h11;
    M[15:8]    = 8'h22;
    M[23:16]   = 8'h33;
  endtask

  // One request; checks mp_len, first-byte timing, done latency, err and return to idle.
  task automatic run(input string name, input int cl, input int ml, input bit exp_err,
                     input bit tog, input bit poke);
    int mp;
    int n;
    bit seen;
    mp = 2 + cl + ml;
    @(posedge clk); #1;
    tog_mode = tog;
    ctx_len  = 16'(cl);
    msg_len  = 16'(ml);
    start    = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    ctx_len = 16'h0005;
    msg_len = 16'h0001;
    n = 1;
    chk({name, "_mp_len"}, 32'(mp_len), 32'(mp));
    chk({name, "_busy"}, 32'(busy), 32'd1);
    chk({name, "_first_valid"}, 32'(out_valid), exp_err ? 32'd0 : 32'd1);
    seen = 1'b0;
    while (n < 20000 && !seen) begin
      if (poke && n == 3) begin
        start   = 1'b1;
        ctx_len = 16'h0000;
        msg_len = 16'h0000;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
    if (!tog) chk({name, "_done_cycle"}, 32'(n), exp_err ? 32'd2 : 32'(mp + 2));
    chk({name, "_err"}, 32'(err), 32'(exp_err));
    tog_mode = 1'b0;
    @(posedge clk); #1;
    chk({name, "_done_pulse"}, 32'({done, err}), 32'd0);
    chk({name, "_idle"}, 32'(busy), 32'd0);
    chk({name, "_mp_len_kept"}, 32'(mp_len), 32'(mp));
    chk({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    bit saw_done;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", 32'({out_valid, out_last, busy, done, err}), 32'd0);
    chk("reset_data", 32'({out_data, mp_len}), 32'd0);
    rst = 1'b1;

    ctx = '0;
    M   = '0;
    exp_q.push_back(9'h000);
    exp_q.push_back(9'h100);
    run("empty", 0, 0, 1'b0, 1'b0, 1'b0);

    load_ab_123();
    push_ab_123();
    run("ab_123", 2, 3, 1'b0, 1'b0, 1'b0);

    push_ab_123();
    run("ab_123_stall", 2, 3, 1'b0, 1'b1, 1'b0);

    run("ctx_too_long", 300, 4, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 254; i++) ctx[8*i +: 8] = 8'(i) ^ 8'h5A;
    for (int i = 0; i < 3459; i++) M[8*i +: 8] = 8'(i * 3 + 1);
    push_seq(254, 3459);
    run("max_len", 254, 3459, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) ctx[8*i +: 8] = 8'(i + 8'hA0);
    push_seq(10, 5);
    @(posedge clk); #1;
    ctx_len = 16'd10;
    msg_len = 16'd5;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_outs", 32'({out_valid, out_last, busy, done, err}), 32'd0);
    chk("abort_data", 32'({out_data, mp_len}), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    saw_done = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    chk("abort_no_done", 32'(saw_done), 32'd0);

    load_ab_123();
    push_ab_123();
    run("start_while_busy", 2, 3, 1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
